// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and defaults for the decode-side hazard/forwarding unit.
package hazard_scoreboard_pkg;

    localparam int HZ_NUM_FWD = 3;   // execute, memory, writeback
    localparam int HZ_LAT_W   = 6;   // multi-cycle latency field width
    localparam int HZ_REG_W   = 5;   // architectural register address width
    localparam int HZ_XLEN    = 64;  // default data width

    typedef logic [HZ_REG_W-1:0] reg_addr_t;

    // One producer stage as seen by the forwarding network.
    typedef struct packed {
        logic               valid;
        reg_addr_t          dst;
        logic [HZ_XLEN-1:0] data;
    } fwd_bus_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    // A producer matches a source when it writes that register and the
    // register is not x0 (x0 always reads as zero from the regfile).
    function automatic logic src_hit(input logic      vld,
                                     input reg_addr_t dst,
                                     input reg_addr_t src);
        return vld && (dst == src) && (src != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Single-source priority mux: picks the youngest producer stage writing
// the requested register, and flags a load-use hazard when that stage is
// an execute-stage load whose data does not exist yet.
module hazard_scoreboard_fwd_select
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN    = HZ_XLEN,
    parameter int NUM_FWD = HZ_NUM_FWD
) (
    input  logic [HZ_REG_W-1:0]         src_i,
    input  logic [NUM_FWD-1:0]          fwd_valid_i,
    input  logic [NUM_FWD*HZ_REG_W-1:0] fwd_dst_i,
    input  logic [NUM_FWD*XLEN-1:0]     fwd_data_i,
    input  logic                        fwd_is_load_i,
    output logic                        sel_o,
    output logic [XLEN-1:0]             data_o,
    output logic                        luse_o
);

    logic            hit;
    logic            hit0;
    logic [XLEN-1:0] hit_data;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        hit      = 1'b0;
        hit0     = 1'b0;
        hit_data = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (src_hit(fwd_valid_i[i], fwd_dst_i[i*HZ_REG_W +: HZ_REG_W], src_i)) begin
                hit      = 1'b1;
                hit0     = (i == 0);
                hit_data = fwd_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // A youngest-match load blocks forwarding entirely; older stages hold
    // stale values for that register and must not be used.
    assign luse_o = hit0 && fwd_is_load_i;
    assign sel_o  = hit && !luse_o;
    assign data_o = sel_o ? hit_data : '0;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: operand forwarding, load-use stalls, a single
// outstanding multi-cycle op tracker and a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = HZ_NUM_FWD,
    parameter int LAT_W   = HZ_LAT_W,
    parameter int CNT_W   = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        id_valid_i,
    input  logic [NUM_SRC*HZ_REG_W-1:0] id_src_i,
    input  logic                        id_mc_issue_i,
    input  logic [HZ_REG_W-1:0]         id_mc_dst_i,
    input  logic [LAT_W-1:0]            id_mc_lat_i,
    input  logic [NUM_FWD-1:0]          fwd_valid_i,
    input  logic [NUM_FWD*HZ_REG_W-1:0] fwd_dst_i,
    input  logic [NUM_FWD*XLEN-1:0]     fwd_data_i,
    input  logic                        fwd_is_load_i,
    input  logic                        flush_i,
    output logic                        stall_o,
    output logic                        clear_o,
    output logic [NUM_SRC-1:0]          src_sel_o,
    output logic [NUM_SRC*XLEN-1:0]     src_data_o,
    output logic                        mc_busy_o,
    output logic [HZ_REG_W-1:0]         mc_dst_o,
    output logic                        mc_done_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    mc_state_e             state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [HZ_REG_W-1:0]   mc_dst_q, mc_dst_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC-1:0]    src_luse;
    logic [NUM_SRC-1:0]    src_mcdep;
    logic                  luse, mcdep, mcstruct, stall;
    logic                  mc_accept;
    logic                  mc_busy, mc_done;

    // Per-source forwarding and dependency on the outstanding op.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [HZ_REG_W-1:0] src;
        assign src = id_src_i[s*HZ_REG_W +: HZ_REG_W];

        hazard_scoreboard_fwd_select #(
            .XLEN    (XLEN),
            .NUM_FWD (NUM_FWD)
        ) u_fwd_select (
            .src_i         (src),
            .fwd_valid_i   (fwd_valid_i),
            .fwd_dst_i     (fwd_dst_i),
            .fwd_data_i    (fwd_data_i),
            .fwd_is_load_i (fwd_is_load_i),
            .sel_o         (src_sel_o[s]),
            .data_o        (src_data_o[s*XLEN +: XLEN]),
            .luse_o        (src_luse[s])
        );

        assign src_mcdep[s] = mc_busy && (src != '0) && (src == mc_dst_q);
    end

    // Hazard sources; mcdep still holds in the done cycle because the
    // result only becomes visible through the normal stages afterwards.
    assign luse     = id_valid_i && (|src_luse);
    assign mcdep    = id_valid_i && (|src_mcdep);
    assign mcstruct = id_valid_i && id_mc_issue_i && mc_busy && !mc_done;
    assign stall    = (luse || mcdep || mcstruct) && !flush_i;
    assign stall_o  = stall;
    assign clear_o  = stall;

    assign mc_accept = id_valid_i && id_mc_issue_i && !stall && !flush_i;

    // Tracker state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mc_dst_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mc_dst_q <= mc_dst_d;
        end
    end

    // Tracker next state: count down, retire on zero, or reload back-to-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_dst_d = mc_dst_q;
        case (state_q)
            IDLE: begin
                if (mc_accept) begin
                    state_d  = BUSY;
                    cnt_d    = id_mc_lat_i - LAT_W'(1);
                    mc_dst_d = id_mc_dst_i;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else if (mc_accept) begin
                    cnt_d    = id_mc_lat_i - LAT_W'(1);
                    mc_dst_d = id_mc_dst_i;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tracker outputs decoded from the registered state.
    always_comb begin
        mc_busy = (state_q == BUSY);
        mc_done = mc_busy && (cnt_q == '0);
    end

    assign mc_busy_o = mc_busy;
    assign mc_done_o = mc_done;
    assign mc_dst_o  = mc_dst_q;

    // Stall counter next value, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus pushes expected observations into a queue and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

    localparam int XLEN = 64;
    localparam int NS   = 2;
    localparam int NF   = 3;
    localparam int LW   = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [NS*5-1:0] id_src;
    logic            id_mc_issue;
    logic [4:0]      id_mc_dst;
    logic [LW-1:0]   id_mc_lat;
    logic [NF-1:0]   fwd_valid;
    logic [NF*5-1:0] fwd_dst;
    logic [NF*XLEN-1:0] fwd_data;
    logic            fwd_is_load;
    logic            flush;

    logic            stall, clear, mc_busy, mc_done;
    logic [NS-1:0]   src_sel;
    logic [NS*XLEN-1:0] src_data;
    logic [4:0]      mc_dst;
    logic [31:0]     stall_cnt;

    logic            s_stall, s_clear, s_busy, s_done;
    logic [NS-1:0]   s_sel;
    logic [NS*XLEN-1:0] s_data;
    logic [4:0]      s_dst;
    logic [3:0]      sat_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .LAT_W(LW), .CNT_W(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_src_i(id_src),
        .id_mc_issue_i(id_mc_issue), .id_mc_dst_i(id_mc_dst), .id_mc_lat_i(id_mc_lat),
        .fwd_valid_i(fwd_valid), .fwd_dst_i(fwd_dst), .fwd_data_i(fwd_data),
        .fwd_is_load_i(fwd_is_load), .flush_i(flush), .stall_o(stall), .clear_o(clear),
        .src_sel_o(src_sel), .src_data_o(src_data), .mc_busy_o(mc_busy), .mc_dst_o(mc_dst),
        .mc_done_o(mc_done), .stall_cnt_o(stall_cnt)
    );

    hazard_scoreboard #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .LAT_W(LW), .CNT_W(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_src_i(id_src),
        .id_mc_issue_i(id_mc_issue), .id_mc_dst_i(id_mc_dst), .id_mc_lat_i(id_mc_lat),
        .fwd_valid_i(fwd_valid), .fwd_dst_i(fwd_dst), .fwd_data_i(fwd_data),
        .fwd_is_load_i(fwd_is_load), .flush_i(flush), .stall_o(s_stall), .clear_o(s_clear),
        .src_sel_o(s_sel), .src_data_o(s_data), .mc_busy_o(s_busy), .mc_dst_o(s_dst),
        .mc_done_o(s_done), .stall_cnt_o(sat_cnt)
    );

    typedef enum int {
        SIG_STALL, SIG_CLEAR, SIG_SEL, SIG_D0, SIG_D1,
        SIG_BUSY, SIG_DST, SIG_DONE, SIG_CNT, SIG_SAT
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic expect_v(input string n, input sig_e s, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] actual(input sig_e s);
        case (s)
            SIG_STALL: return 64'(stall);
            SIG_CLEAR: return 64'(clear);
            SIG_SEL:   return 64'(src_sel);
            SIG_D0:    return src_data[0 +: XLEN];
            SIG_D1:    return src_data[XLEN +: XLEN];
            SIG_BUSY:  return 64'(mc_busy);
            SIG_DST:   return 64'(mc_dst);
            SIG_DONE:  return 64'(mc_done);
            SIG_CNT:   return 64'(stall_cnt);
            SIG_SAT:   return 64'(sat_cnt);
            default:   return 64'hDEAD;
        endcase
    endfunction

    task automatic check_now(input string n, input sig_e s, input logic [63:0] v);
        logic [63:0] a;
        a = actual(s);
        checks++;
        if (a !== v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (immediate)", n, a, v);
        end
    endtask

    // Monitor: compare every pending observation mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual(e.sig);
            checks++;
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.exp);
            end
        end
    end

    task automatic idle();
        id_valid    = 1'b0;
        id_src      = '0;
        id_mc_issue = 1'b0;
        id_mc_dst   = '0;
        id_mc_lat   = '0;
        fwd_valid   = '0;
        fwd_dst     = '0;
        fwd_data    = '0;
        fwd_is_load = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] dst, input logic [LW-1:0] lat);
        id_valid    = 1'b1;
        id_mc_issue = 1'b1;
        id_mc_dst   = dst;
        id_mc_lat   = lat;
    endtask

    // Stage0 load of x7, stage1 holds x7=0x55, source 1 reads x7.
    task automatic load_use(input logic is_load);
        id_valid    = 1'b1;
        fwd_valid   = 3'b011;
        fwd_dst     = {5'd0, 5'd7, 5'd7};
        fwd_data    = {64'h0, 64'h55, 64'h77};
        fwd_is_load = is_load;
        id_src      = {5'd7, 5'd0};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset state.
        cyc();
        check_now("rst_busy_now", SIG_BUSY, 0);
        check_now("rst_cnt_now", SIG_CNT, 0);
        check_now("rst_stall_now", SIG_STALL, 0);
        expect_v("rst_busy", SIG_BUSY, 0);
        expect_v("rst_dst", SIG_DST, 0);
        expect_v("rst_done", SIG_DONE, 0);
        expect_v("rst_cnt", SIG_CNT, 0);
        expect_v("rst_sat", SIG_SAT, 0);
        expect_v("rst_stall", SIG_STALL, 0);
        expect_v("rst_sel", SIG_SEL, 0);

        // Priority: youngest matching stage wins.
        cyc();
        rst_n     = 1'b1;
        id_valid  = 1'b1;
        fwd_valid = 3'b111;
        fwd_dst   = {5'd5, 5'd5, 5'd5};
        fwd_data  = {64'hC, 64'hB, 64'hA};
        id_src    = {5'd0, 5'd5};
        expect_v("prio_sel", SIG_SEL, 2'b01);
        expect_v("prio_d0", SIG_D0, 64'hA);
        expect_v("prio_d1", SIG_D1, 0);
        expect_v("prio_stall", SIG_STALL, 0);

        cyc();
        id_valid  = 1'b1;
        fwd_valid = 3'b110;
        fwd_dst   = {5'd5, 5'd5, 5'd5};
        fwd_data  = {64'hC, 64'hB, 64'hA};
        id_src    = {5'd5, 5'd5};
        expect_v("prio2_sel", SIG_SEL, 2'b11);
        expect_v("prio2_d0", SIG_D0, 64'hB);
        expect_v("prio2_d1", SIG_D1, 64'hB);

        // x0 is never forwarded.
        cyc();
        id_valid  = 1'b1;
        fwd_valid = 3'b111;
        fwd_dst   = '0;
        fwd_data  = {64'hC, 64'hB, 64'hA};
        id_src    = '0;
        expect_v("x0_sel", SIG_SEL, 0);
        expect_v("x0_d0", SIG_D0, 0);

        // Load-use stall, then forward once the load resolves.
        cyc();
        load_use(1'b1);
        expect_v("luse_stall", SIG_STALL, 1);
        expect_v("luse_clear", SIG_CLEAR, 1);
        expect_v("luse_sel", SIG_SEL, 0);
        expect_v("luse_d1", SIG_D1, 0);

        cyc();
        load_use(1'b0);
        expect_v("nold_stall", SIG_STALL, 0);
        expect_v("nold_sel", SIG_SEL, 2'b10);
        expect_v("nold_d1", SIG_D1, 64'h77);
        expect_v("nold_cnt", SIG_CNT, 1);

        // Flush overrides a pending load-use stall.
        cyc();
        load_use(1'b1);
        flush = 1'b1;
        expect_v("flush_stall", SIG_STALL, 0);
        expect_v("flush_clear", SIG_CLEAR, 0);

        cyc();
        expect_v("flush_cnt", SIG_CNT, 1);
        expect_v("flush_busy", SIG_BUSY, 0);

        // Multi-cycle op x9 latency 4 with a dependent waiting on it.
        cyc();
        issue(5'd9, 6'd4);
        expect_v("mc_iss_stall", SIG_STALL, 0);
        expect_v("mc_iss_busy", SIG_BUSY, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            id_valid = 1'b1;
            id_src   = {5'd0, 5'd9};
            expect_v("mc_busy", SIG_BUSY, 1);
            expect_v("mc_dst", SIG_DST, 9);
            expect_v("mc_done", SIG_DONE, (k == 3) ? 64'd1 : 64'd0);
            expect_v("mc_dep_stall", SIG_STALL, 1);
        end
        cyc();
        check_now("mc_expired_busy", SIG_BUSY, 0);
        id_valid = 1'b1;
        id_src   = {5'd0, 5'd9};
        expect_v("mc_after_busy", SIG_BUSY, 0);
        expect_v("mc_after_stall", SIG_STALL, 0);
        expect_v("mc_after_cnt", SIG_CNT, 5);

        // Back-to-back: second issue waits for done, flush in between.
        cyc();
        issue(5'd9, 6'd3);
        expect_v("b2b_iss_stall", SIG_STALL, 0);
        cyc();
        issue(5'd12, 6'd2);
        expect_v("b2b_struct_stall", SIG_STALL, 1);
        expect_v("b2b_struct_done", SIG_DONE, 0);
        cyc();
        issue(5'd12, 6'd2);
        flush = 1'b1;
        expect_v("b2b_flush_stall", SIG_STALL, 0);
        expect_v("b2b_flush_busy", SIG_BUSY, 1);
        cyc();
        issue(5'd12, 6'd2);
        expect_v("b2b_done", SIG_DONE, 1);
        expect_v("b2b_acc_stall", SIG_STALL, 0);
        expect_v("b2b_old_dst", SIG_DST, 9);
        cyc();
        expect_v("b2b_busy", SIG_BUSY, 1);
        expect_v("b2b_dst", SIG_DST, 12);
        expect_v("b2b_done0", SIG_DONE, 0);
        expect_v("b2b_cnt", SIG_CNT, 6);
        cyc();
        expect_v("b2b_done1", SIG_DONE, 1);
        cyc();
        expect_v("b2b_idle", SIG_BUSY, 0);

        // Latency 1: done in the cycle right after issue.
        cyc();
        issue(5'd3, 6'd1);
        cyc();
        expect_v("lat1_busy", SIG_BUSY, 1);
        expect_v("lat1_done", SIG_DONE, 1);
        expect_v("lat1_dst", SIG_DST, 3);
        cyc();
        expect_v("lat1_idle", SIG_BUSY, 0);

        // Asynchronous reset in the middle of a busy op.
        cyc();
        issue(5'd20, 6'd5);
        cyc();
        expect_v("pre_rst_busy", SIG_BUSY, 1);
        expect_v("pre_rst_dst", SIG_DST, 20);
        cyc();
        rst_n = 1'b0;
        expect_v("arst_busy", SIG_BUSY, 0);
        expect_v("arst_dst", SIG_DST, 0);
        expect_v("arst_done", SIG_DONE, 0);
        expect_v("arst_cnt", SIG_CNT, 0);
        expect_v("arst_sat", SIG_SAT, 0);
        cyc();
        rst_n = 1'b1;
        expect_v("rel_cnt", SIG_CNT, 0);

        // Saturation: 20 stalled cycles against a 4-bit counter.
        for (int n = 0; n < 20; n++) begin
            cyc();
            load_use(1'b1);
            expect_v("sat_stall", SIG_STALL, 1);
            expect_v("sat_cnt32", SIG_CNT, 64'(n));
            expect_v("sat_cnt4", SIG_SAT, (n > 15) ? 64'd15 : 64'(n));
        end
        cyc();
        expect_v("sat_final32", SIG_CNT, 20);
        expect_v("sat_final4", SIG_SAT, 15);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding unit for the pipelined RISC-V core; sits beside the decode stage.
- Resolves source operands for NUM_SRC decode-stage sources against NUM_FWD producer stages, ordered youngest first.
- Generates load-use stalls.
- Tracks one outstanding multi-cycle operation (mul/div) with a latency countdown and stalls dependents until its writeback.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- XLEN, 64, operand/data width.
- NUM_SRC, 2, number of decode-stage source operands.
- NUM_FWD, 3, producer stages; index 0 = execute (youngest), NUM_FWD-1 = writeback.
- LAT_W, 6, width of the multi-cycle latency field.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_src  in  NUM_SRC*5  source register addresses
- id_mc_issue  in  1  decode instruction is a multi-cycle op and wants to issue
- id_mc_dst  in  5  destination of that op
- id_mc_lat  in  LAT_W  cycles until its result is written back (≥1)
- fwd_valid  in  NUM_FWD  producer writes a register
- fwd_dst  in  NUM_FWD*5  producer destinations
- fwd_data  in  NUM_FWD*XLEN  producer results
- fwd_is_load  in  1  stage-0 producer is a load (data not yet available)
- flush  in  1  branch/exception flush of decode
- stall  out  1  freeze fetch/decode
- clear  out  1  insert bubble into execute
- src_sel  out  NUM_SRC  1 = use src_data instead of regfile
- src_data  out  NUM_SRC*XLEN  forwarded operand
- mc_busy  out  1  multi-cycle op outstanding
- mc_dst_o  out  5  destination of the outstanding op
- mc_done  out  1  one-cycle pulse on the final countdown cycle
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
Forwarding (combinational):
- Per source s, pick the lowest-index stage i with fwd_valid[i] && fwd_dst[i]==id_src[s] && id_src[s]!=0.
- Register x0 is never forwarded: src_sel=0, src_data=0.
- No match: src_sel=0, src_data=0.
- A stage-0 match with fwd_is_load=1 is not forwarded (src_sel=0); it raises a load-use hazard instead.

Hazards (combinational):
- luse: id_valid && stage-0 load match on any nonzero source.
- mcdep: id_valid && mc_busy && any nonzero id_src == mc_dst_o.
- mcstruct: id_valid && id_mc_issue && mc_busy && !mc_done.
- stall = clear = (luse | mcdep | mcstruct) && !flush. Flush overrides stall.

Multi-cycle tracker (sequential):
- States: IDLE, BUSY.
- IDLE → BUSY when id_valid && id_mc_issue && !stall && !flush. Latch mc_dst_o=id_mc_dst and cnt=id_mc_lat-1.
- BUSY: cnt decrements each cycle. mc_done=1 when cnt==0.
- BUSY → IDLE on the cnt==0 cycle, unless a new issue is accepted that same cycle; then reload (back-to-back).
- mcdep still asserts in the mc_done cycle; the dependent issues the next cycle via normal stage forwarding.
- id_mc_lat==1 gives mc_done in the cycle after issue.
- flush does not cancel an already-issued op.

Performance counter:
- stall_cnt increments every cycle stall=1; holds at all-ones.

Reset:
- Asynchronous assertion; takes effect immediately, including mid-operation.
- State=IDLE; mc_busy=0, mc_dst_o=0, mc_done=0, cnt=0, stall_cnt=0.
- Combinational outputs follow from the reset state.

Decomposition:
- Shared package pipes:
  - hazard_cfg constants (NUM_FWD default, LAT_W);
  - typedef fwd_bus_t {valid, dst, data};
  - typedef mc_state_e {IDLE, BUSY}.
- One sub-module, fwd_select: a single-source priority mux over NUM_FWD stages, instantiated NUM_SRC times by generate.

Test Plan:
- Priority/x0: fwd_valid=3'b111, all dst=5, data 0xA/0xB/0xC, id_src[0]=5 → src_sel[0]=1, src_data=0xA. Repeat with id_src[0]=0 and all dst=0 → src_sel=0.
- Load-use: stage0 dst=7 with fwd_is_load=1, stage1 dst=7 data 0x55, id_src[1]=7 → stall=clear=1, src_sel[1]=0. Next cycle with fwd_is_load=0 → stall=0.
- Multi-cycle: issue mc dst=9 lat=4 → mc_busy for 4 cycles, mc_done in the 4th. A dependent on x9 stalls exactly those 4 cycles → stall_cnt=4.
- Back-to-back: second mc issue presented during BUSY stalls until the mc_done cycle, is accepted there; mc_busy stays 1 and mc_dst_o updates.
- Flush/reset: flush while a load-use stall is pending → stall=0, tracker unaffected. Assert reset mid-BUSY → mc_busy=0 and stall_cnt=0 immediately (asynchronously).
- Saturation: force stall for more than 2^CNT_W cycles with CNT_W overridden to 4 → stall_cnt holds at 15.
